weighted_rr_arbiter: RTL and testbench
======================================

Name: weighted_rr_arbiter

Overview:
Parametrised weighted round-robin arbiter. It generalises the fixed single-cycle round-robin arbiter to N requesters, each with a programmable burst weight. A granted requester holds the grant for up to weight[i] consecutive cycles while it keeps requesting, then priority rotates. It sits in front of shared resources (bus, memory port) where masters need bounded, proportional bandwidth.

Parameters:
N, 4, number of requesters (N >= 1)
WW, 4, bit width of each per-requester weight and of the credit counter
IDW, $clog2(N) (minimum 1), width of grant_id

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous active-low reset (0 = reset asserted, sampled on posedge clk)
req  input  N  request vector; req[i] high = requester i wants the resource
weight  input  N*WW  packed weights; requester i uses bits [i*WW +: WW]; value 0 is treated as 1
grant  output  N  registered one-hot grant; all zero when idle
grant_valid  output  1  registered; equals |grant
grant_id  output  IDW  registered binary index of the granted requester; 0 when idle
credit  output  WW  registered remaining cycles in the current burst, including the current cycle; 0 when idle

Behaviour:
- Reset (reset==0 at posedge): grant=0, grant_valid=0, grant_id=0, credit=0, rotation pointer ptr=0, state=IDLE. Takes priority over every other event, including mid-burst.
- Latency: 1 cycle. req sampled at edge t drives grant after edge t; there is no combinational path from req to grant.
- States: IDLE (no owner) and BUSY (owner g).
- BUSY hold:
  - Condition: req[g]==1 and credit>1.
  - Action: grant unchanged, credit decrements by 1.
- Re-arbitration occurs when any of these holds:
  - state is IDLE;
  - req[g]==0;
  - credit==1.
- Re-arbitration rule:
  - Scan req starting at index ptr, upward, wrapping modulo N; the first set bit w wins.
  - Winner found: grant<=onehot(w), grant_id<=w, credit<=max(weight[w],1), ptr<=(w+1) mod N, state BUSY.
  - No bit set: grant<=0, grant_id<=0, credit<=0, state IDLE, ptr unchanged.
- No dead cycle on handover. When the owner drops req or exhausts its credit, the next requester's grant appears at the very next edge.
- Weight is sampled only at burst start. Changes to weight[g] mid-burst are ignored until g's next burst.
- If the owner exhausts its credit and is the only requester, it is re-granted with a fresh credit at the next edge, with no gap.
- If the owner drops req on the same edge its credit would expire, this is ordinary re-arbitration: no extra cycle.
- N==1: grant[0] follows req[0] delayed by one cycle; credit reloads on expiry.
- Invariants (for assertions):
  - $onehot0(grant);
  - grant_valid == (grant != 0);
  - grant[grant_id] == grant_valid;
  - grant[i] implies $past(req[i]);
  - credit is 0 iff grant_valid is 0;
  - 1 <= credit <= max(weight,1) while valid.
- Fairness: with req held continuously, requester i waits at most the sum of the other requesters' effective weights before being granted.
- Arithmetic:
  - credit is unsigned WW bits and never wraps below 1 while valid;
  - ptr is IDW bits and wraps from N-1 to 0; correct for non-power-of-2 N.

Test Plan:
- Reset: N=4, req=1111 while reset=0 for 3 edges -> grant=0000 and credit=0 throughout. First edge with reset=1 -> grant=0001, grant_id=0, credit=weight[0].
- Single requester: weights all 1, req=0010 held 5 cycles -> grant=0010 on every cycle from the second edge onward, credit stays 1, no gaps. Then req=0000 -> grant=0000 next edge.
- Weighted rotation: weights {w0=1,w1=2,w2=3,w3=4}, req=1111 held -> grant repeats the period-10 pattern 0001, 0010×2, 0100×3, 1000×4. Credit counts down 4,3,2,1 during the 1000 burst.
- Early release: w0=4, w1=1, req=0011 -> grant=0001 for 2 cycles. Then drop req[0] -> grant=0010 at the next edge with credit=1; ptr now 2, so the next winner search starts at index 2.
- Weight edge cases:
  - weight[2]=0 with req=0100 -> credit=1 and grant re-issued every cycle.
  - Changing weight[3] from 4 to 1 at the second cycle of a 1000 burst -> burst still lasts 4 cycles.
- Reset mid-burst: w3=4, grant=1000 with credit=3; assert reset=0 for 1 edge -> grant=0000 and ptr=0. Release with req=1001 -> grant=0001 (not 1000).

Source files
------------

// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle for weighted_rr_arbiter.
//   master : requester side, drives req and packed weights, observes the grant
//   slave  : arbiter side, samples req/weight, drives registered grant outputs
// Signals:
//   req[N]          request vector
//   weight[N*WW]    packed per-requester burst weights, requester i at [i*WW +: WW]
//   grant[N]        one-hot grant, zero when idle
//   grant_valid     |grant
//   grant_id[IDW]   binary index of the granted requester, 0 when idle
//   credit[WW]      cycles left in the current burst including this one, 0 when idle
interface weighted_rr_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned WW  = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [WW-1:0]   credit;

  modport master (
    output req, weight,
    input  grant, grant_valid, grant_id, credit
  );

  modport slave (
    input  req, weight,
    output grant, grant_valid, grant_id, credit
  );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter for N requesters.
// A winner keeps the grant for up to max(weight,1) consecutive cycles while it
// keeps requesting; then priority rotates to the index after the winner.
// All outputs are registered: req sampled at an edge affects grant after it.
// Ports:
//   clk    : clock, all logic on posedge
//   reset  : synchronous active-low reset
//   bus    : weighted_rr_arbiter_if.slave (req, weight in; grant, grant_valid,
//            grant_id, credit out)
module weighted_rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned WW  = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  weighted_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [N-1:0]   grant_q;
  logic           grant_valid_q;
  logic [IDW-1:0] grant_id_q;
  logic [WW-1:0]  credit_q;

  logic           found;
  logic [IDW-1:0] win;
  int unsigned    scan_idx;
  logic [WW-1:0]  win_weight;
  logic [WW-1:0]  eff_weight;
  logic [N-1:0]   win_onehot;
  logic [IDW-1:0] next_ptr;
  logic           hold;

  // Rotating priority scan: first requester at or after ptr, wrapping mod N.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = (32'(ptr) + k) % N;
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_weight = bus.weight[32'(win)*WW +: WW];
    eff_weight = (win_weight == '0) ? WW'(1) : win_weight;
    win_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      win_onehot[i] = (32'(win) == i);
    end
    next_ptr = (32'(win) == N - 1) ? '0 : win + 1'b1;
    hold     = (state == BUSY) && bus.req[grant_id_q] && (credit_q > WW'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      credit_q      <= '0;
    end else if (hold) begin
      credit_q <= credit_q - WW'(1);
    end else if (found) begin
      // Re-arbitration covers idle, released and expired owners alike, so
      // handover (or self re-grant of a lone requester) has no dead cycle.
      state         <= BUSY;
      ptr           <= next_ptr;
      grant_q       <= win_onehot;
      grant_valid_q <= 1'b1;
      grant_id_q    <= win;
      credit_q      <= eff_weight;
    end else begin
      state         <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      credit_q      <= '0;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.credit      = credit_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed-vector bench for weighted_rr_arbiter (N=4, WW=4).
// A driver applies one vector per cycle and queues the hand-computed response
// expected after the following edge; a monitor pops and compares each cycle.
module tb_weighted_rr_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned WW  = 4;
  localparam int unsigned IDW = 2;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] wt;
    logic [3:0]  g;
    logic [1:0]  id;
    logic [3:0]  cr;
  } step_t;

  typedef struct {
    int          num;
    logic [3:0]  g;
    logic [1:0]  id;
    logic [3:0]  cr;
  } exp_t;

  logic clk;
  logic reset;

  step_t steps[$];
  exp_t  exp_q[$];

  int checks;
  int errors;

  weighted_rr_arbiter_if #(.N(N), .WW(WW), .IDW(IDW)) bus ();

  weighted_rr_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] q, input logic [15:0] w,
                     input logic [3:0] g, input logic [1:0] id, input logic [3:0] cr);
    step_t s;
    s.rst_n = r; s.req = q; s.wt = w; s.g = g; s.id = id; s.cr = cr;
    steps.push_back(s);
  endtask

  task automatic check(input string name, input int num, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, num, got, want);
    end
  endtask

  // Monitor: the DUT presents a registered response every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant",       e.num, 32'(bus.grant),       32'(e.g));
        check("grant_id",    e.num, 32'(bus.grant_id),    32'(e.id));
        check("credit",      e.num, 32'(bus.credit),      32'(e.cr));
        check("grant_valid", e.num, 32'(bus.grant_valid), 32'(e.g != 4'b0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver
  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    reset      = 1'b0;
    bus.req    = '0;
    bus.weight = '0;

    // weights packed {w3,w2,w1,w0}
    // reset held with all requesting
    add(0, 4'b1111, 16'h4321, 4'b0000, 2'd0, 4'd0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 2'd0, 4'd0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 2'd0, 4'd0);
    // release: requester 0 first, then period-10 weighted rotation
    add(1, 4'b1111, 16'h4321, 4'b0001, 2'd0, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b0010, 2'd1, 4'd2);
    add(1, 4'b1111, 16'h4321, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd3);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd2);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd4);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd3);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd2);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b0001, 2'd0, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b0010, 2'd1, 4'd2);
    add(1, 4'b1111, 16'h4321, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd3);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd2);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd4);
    // w3 drops to 1 in the second burst cycle: burst still runs 4 cycles
    add(1, 4'b1111, 16'h1321, 4'b1000, 2'd3, 4'd3);
    add(1, 4'b1111, 16'h1321, 4'b1000, 2'd3, 4'd2);
    add(1, 4'b1111, 16'h1321, 4'b1000, 2'd3, 4'd1);
    add(1, 4'b1111, 16'h1321, 4'b0001, 2'd0, 4'd1);
    add(1, 4'b1111, 16'h1321, 4'b0010, 2'd1, 4'd2);
    add(1, 4'b1111, 16'h1321, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b1111, 16'h1321, 4'b0100, 2'd2, 4'd3);
    add(1, 4'b1111, 16'h1321, 4'b0100, 2'd2, 4'd2);
    add(1, 4'b1111, 16'h4321, 4'b0100, 2'd2, 4'd1);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd4);
    add(1, 4'b1111, 16'h4321, 4'b1000, 2'd3, 4'd3);
    // reset mid-burst, then 1001 must pick requester 0
    add(0, 4'b1111, 16'h4321, 4'b0000, 2'd0, 4'd0);
    add(1, 4'b1001, 16'h4321, 4'b0001, 2'd0, 4'd1);
    add(1, 4'b1001, 16'h4321, 4'b1000, 2'd3, 4'd4);
    // early release with w0=4, w1=1
    add(1, 4'b0011, 16'h4314, 4'b0001, 2'd0, 4'd4);
    add(1, 4'b0011, 16'h4314, 4'b0001, 2'd0, 4'd3);
    add(1, 4'b0010, 16'h4314, 4'b0010, 2'd1, 4'd1);
    // ptr is 2: scan 2,3,0 picks 0 rather than 1
    add(1, 4'b0011, 16'h4314, 4'b0001, 2'd0, 4'd4);
    add(1, 4'b0000, 16'h4314, 4'b0000, 2'd0, 4'd0);
    // single requester, weights all 1: continuous re-grant
    add(1, 4'b0010, 16'h1111, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b0010, 16'h1111, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b0010, 16'h1111, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b0010, 16'h1111, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b0010, 16'h1111, 4'b0010, 2'd1, 4'd1);
    add(1, 4'b0000, 16'h1111, 4'b0000, 2'd0, 4'd0);
    // weight 0 treated as 1
    add(1, 4'b0100, 16'h1011, 4'b0100, 2'd2, 4'd1);
    add(1, 4'b0100, 16'h1011, 4'b0100, 2'd2, 4'd1);
    add(1, 4'b0100, 16'h1011, 4'b0100, 2'd2, 4'd1);
    // owner drops req on its expiring cycle
    add(1, 4'b0001, 16'h1011, 4'b0001, 2'd0, 4'd1);
    // reset with ptr at 1: afterwards scan must restart at 0
    add(0, 4'b0001, 16'h1111, 4'b0000, 2'd0, 4'd0);
    add(1, 4'b1001, 16'h1111, 4'b0001, 2'd0, 4'd1);

    for (int i = 0; i < steps.size(); i++) begin
      @(negedge clk);
      reset      = steps[i].rst_n;
      bus.req    = steps[i].req;
      bus.weight = steps[i].wt;
      e.num = i;
      e.g   = steps[i].g;
      e.id  = steps[i].id;
      e.cr  = steps[i].cr;
      exp_q.push_back(e);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
